// File: rtl/uart_cmd_pkg.sv
// Purpose: shared command/reply codes, FSM state encoding and counter sizing
//          helper for the UART command sequencer.
// Contents:
//   CMD_WR / CMD_RD          host command bytes ('W' / 'R')
//   RSP_OK / RSP_BAD / RSP_TMO  reply bytes ('K' / '?' / 'E')
//   state_e                  sequencer state encoding
//   cnt_width()              width of the shared timeout counter
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  localparam logic [7:0] RSP_TMO = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_BUS_WAIT = 3'd3,
    ST_SEND     = 3'd4
  } state_e;

  // Width able to hold max(a, b); never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Purpose: saturating up-counter of elapsed clocks with an expiry compare.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_load           load i_load_val this cycle (wins over i_en)
//   i_load_val       value loaded
//   i_en             count one clock; holds at all-ones instead of wrapping
//   i_limit          expiry threshold; 0 disables expiry
//   o_expired_c      combinational: count has reached i_limit
module timeout_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_en,
  input  logic [Width-1:0] i_limit,
  output logic             o_expired_c
);

  logic [Width-1:0] r_cnt;

  // Count register: load has priority, increment saturates.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != {Width{1'b1}})) begin
      r_cnt <= r_cnt + Width'(1);
    end
  end

  assign o_expired_c = (i_limit != '0) && (r_cnt >= i_limit);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Purpose: parses 'W' addr data / 'R' addr frames from a UART byte stream,
//          issues one register-bus access per frame and returns one reply byte.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_rx_valid, i_rx_byte   received byte strobe and value
//   o_tx_valid, o_tx_byte   reply byte, held until i_tx_ready
//   i_tx_ready              uart_tx can accept a byte
//   o_bus_wr, o_bus_rd      one-cycle access strobes
//   o_bus_addr, o_bus_wdata access address / write data
//   i_bus_rdata, i_bus_ack  read data and completion
//   o_overrun               byte dropped while busy (same-cycle pulse)
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned FrameTimeout = 100_000,
  parameter int unsigned AckTimeout   = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_ready,
  output logic       o_bus_wr,
  output logic       o_bus_rd,
  output logic [7:0] o_bus_addr,
  output logic [7:0] o_bus_wdata,
  input  logic [7:0] i_bus_rdata,
  input  logic       i_bus_ack,
  output logic       o_overrun
);

  localparam int unsigned CntW = cnt_width(FrameTimeout, AckTimeout);
  localparam logic [CntW-1:0] FrameLim = CntW'(FrameTimeout);
  localparam logic [CntW-1:0] AckLim   = CntW'(AckTimeout);

  state_e r_state;
  state_e w_next_state;

  logic       r_cmd_wr;
  logic       r_tx_valid;
  logic [7:0] r_tx_byte;
  logic       r_bus_wr;
  logic       r_bus_rd;
  logic [7:0] r_bus_addr;
  logic [7:0] r_bus_wdata;

  logic       w_cmd_wr;
  logic [7:0] w_tx_byte;
  logic       w_bus_wr;
  logic       w_bus_rd;
  logic [7:0] w_bus_addr;
  logic [7:0] w_bus_wdata;

  logic            w_cnt_load;
  logic [CntW-1:0] w_cnt_load_val;
  logic            w_cnt_en;
  logic [CntW-1:0] w_cnt_limit;
  logic            w_expired;
  logic            w_is_cmd;

  assign w_is_cmd = (i_rx_byte == CMD_WR) || (i_rx_byte == CMD_RD);

  // Single counter: inter-byte gap while collecting a frame, ack wait in BUS_WAIT.
  timeout_counter #(
    .Width (CntW)
  ) u_timeout (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_cnt_load),
    .i_load_val  (w_cnt_load_val),
    .i_en        (w_cnt_en),
    .i_limit     (w_cnt_limit),
    .o_expired_c (w_expired)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a received byte always wins over a same-cycle timeout.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_rx_valid) w_next_state = w_is_cmd ? ST_GET_ADDR : ST_SEND;
      end
      ST_GET_ADDR: begin
        if (i_rx_valid)     w_next_state = r_cmd_wr ? ST_GET_DATA : ST_BUS_WAIT;
        else if (w_expired) w_next_state = ST_IDLE;
      end
      ST_GET_DATA: begin
        if (i_rx_valid)     w_next_state = ST_BUS_WAIT;
        else if (w_expired) w_next_state = ST_IDLE;
      end
      ST_BUS_WAIT: begin
        if (i_bus_ack || w_expired) w_next_state = ST_SEND;
      end
      ST_SEND: begin
        if (i_tx_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output / datapath next values and counter control.
  // Gap counting starts at 1 on a byte so the count equals clocks since that byte;
  // ack counting starts at 0 in the strobe cycle.
  always_comb begin
    w_cmd_wr       = r_cmd_wr;
    w_tx_byte      = r_tx_byte;
    w_bus_wr       = 1'b0;
    w_bus_rd       = 1'b0;
    w_bus_addr     = r_bus_addr;
    w_bus_wdata    = r_bus_wdata;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = CntW'(1);
    w_cnt_en       = 1'b0;
    w_cnt_limit    = (r_state == ST_BUS_WAIT) ? AckLim : FrameLim;
    unique case (r_state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          w_cmd_wr   = (i_rx_byte == CMD_WR);
          w_cnt_load = 1'b1;
          if (!w_is_cmd) w_tx_byte = RSP_BAD;
        end
      end
      ST_GET_ADDR: begin
        w_cnt_en = 1'b1;
        if (i_rx_valid) begin
          w_bus_addr = i_rx_byte;
          w_cnt_load = 1'b1;
          if (!r_cmd_wr) begin
            w_bus_rd       = 1'b1;
            w_cnt_load_val = '0;
          end
        end
      end
      ST_GET_DATA: begin
        w_cnt_en = 1'b1;
        if (i_rx_valid) begin
          w_bus_wdata    = i_rx_byte;
          w_bus_wr       = 1'b1;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = '0;
        end
      end
      ST_BUS_WAIT: begin
        w_cnt_en = 1'b1;
        if (i_bus_ack)      w_tx_byte = r_cmd_wr ? RSP_OK : i_bus_rdata;
        else if (w_expired) w_tx_byte = RSP_TMO;
      end
      ST_SEND: begin
      end
      default: begin
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmd_wr    <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_byte   <= '0;
      r_bus_wr    <= 1'b0;
      r_bus_rd    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_cmd_wr    <= w_cmd_wr;
      r_tx_valid  <= (w_next_state == ST_SEND);
      r_tx_byte   <= w_tx_byte;
      r_bus_wr    <= w_bus_wr;
      r_bus_rd    <= w_bus_rd;
      r_bus_addr  <= w_bus_addr;
      r_bus_wdata <= w_bus_wdata;
    end
  end

  assign o_tx_valid  = r_tx_valid;
  assign o_tx_byte   = r_tx_byte;
  assign o_bus_wr    = r_bus_wr;
  assign o_bus_rd    = r_bus_rd;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;

  // Drop notification must coincide with the dropped byte, so it is decoded here.
  assign o_overrun = i_rx_valid && !i_rst &&
                     ((r_state == ST_BUS_WAIT) || (r_state == ST_SEND));

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

  localparam int unsigned FT = 40;
  localparam int unsigned AT = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       bus_wr, bus_rd;
  logic [7:0] bus_addr, bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic       overrun;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.FrameTimeout(FT), .AckTimeout(AT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .o_tx_valid(tx_valid), .o_tx_byte(tx_byte), .i_tx_ready(tx_ready),
    .o_bus_wr(bus_wr), .o_bus_rd(bus_rd),
    .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
    .i_bus_rdata(bus_rdata), .i_bus_ack(bus_ack),
    .o_overrun(overrun)
  );

  // Event monitor, sampled on the inactive edge.
  int n_wr = 0, n_rd = 0, n_tx = 0, n_ovr = 0, n_both = 0, n_unstable = 0;
  int cyc = 0, strobe_cyc = 0, valid_cyc = 0;
  logic [7:0] cap_addr = 0, cap_wdata = 0, cap_tx = 0, hold_byte = 0;
  logic prev_valid = 0, prev_hold = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus_wr) begin n_wr <= n_wr + 1; cap_addr <= bus_addr; cap_wdata <= bus_wdata; strobe_cyc <= cyc; end
    if (bus_rd) begin n_rd <= n_rd + 1; cap_addr <= bus_addr; strobe_cyc <= cyc; end
    if (bus_wr && bus_rd) n_both <= n_both + 1;
    if (tx_valid && tx_ready) begin n_tx <= n_tx + 1; cap_tx <= tx_byte; end
    if (tx_valid && !prev_valid) valid_cyc <= cyc;
    if (overrun) n_ovr <= n_ovr + 1;
    if (prev_hold && tx_valid && (tx_byte != hold_byte)) n_unstable <= n_unstable + 1;
    prev_valid <= tx_valid;
    prev_hold  <= tx_valid && !tx_ready;
    hold_byte  <= tx_byte;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_ack(input int delay, input logic [7:0] rd);
    repeat (delay) tick();
    bus_ack = 1'b1; bus_rdata = rd;
    tick();
    bus_ack = 1'b0;
  endtask

  task automatic wait_tx(input string name);
    int n;
    n = 0;
    while (!tx_valid && n < 200) begin tick(); n++; end
    if (!tx_valid) begin
      errors++;
      $display("FAIL %s: tx_valid never rose within 200 cycles", name);
    end
  endtask

  typedef struct {
    logic [7:0] cmd, addr, data;
    int         nbytes;
    int         ack_dly;
    logic [7:0] rdata;
    logic [7:0] exp_tx;
    int         exp_wr, exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int b_wr, b_rd, b_tx, b_ovr;

    vecs[0] = '{8'h57, 8'h10, 8'hA5, 3, 2,  8'h00, 8'h4B, 1, 0};
    vecs[1] = '{8'h52, 8'h22, 8'h00, 2, 0,  8'h3C, 8'h3C, 0, 1};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1, 0,  8'h00, 8'h3F, 0, 0};
    vecs[3] = '{8'h57, 8'hFF, 8'h00, 3, 0,  8'h00, 8'h4B, 1, 0};
    vecs[4] = '{8'h52, 8'h80, 8'h00, 2, 5,  8'hA7, 8'hA7, 0, 1};
    vecs[5] = '{8'h4B, 8'h00, 8'h00, 1, 0,  8'h00, 8'h3F, 0, 0};
    vecs[6] = '{8'h52, 8'h7F, 8'h00, 2, 11, 8'h5A, 8'h5A, 0, 1};
    vecs[7] = '{8'h57, 8'h33, 8'hCC, 3, 11, 8'h00, 8'h4B, 1, 0};

    rst = 1'b1; rx_valid = 0; rx_byte = 0; tx_ready = 1; bus_rdata = 0; bus_ack = 0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset outputs", {23'd0, tx_valid, tx_byte}, 32'd0);
    chk("reset bus", {15'd0, bus_wr, bus_rd, bus_addr, bus_wdata}, 32'd0);
    chk("reset overrun", {31'd0, overrun}, 32'd0);
    tick();

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      b_wr = n_wr; b_rd = n_rd; b_tx = n_tx;
      send_byte(vecs[i].cmd);
      if (vecs[i].nbytes > 1) send_byte(vecs[i].addr);
      if (vecs[i].nbytes > 2) send_byte(vecs[i].data);
      if (vecs[i].nbytes > 1) do_ack(vecs[i].ack_dly, vecs[i].rdata);
      wait_tx($sformatf("v%0d tx wait", i));
      tick();
      chk($sformatf("v%0d tx byte", i), {24'd0, cap_tx}, {24'd0, vecs[i].exp_tx});
      chk($sformatf("v%0d tx count", i), n_tx - b_tx, 1);
      chk($sformatf("v%0d tx dropped", i), {31'd0, tx_valid}, 0);
      chk($sformatf("v%0d wr strobes", i), n_wr - b_wr, vecs[i].exp_wr);
      chk($sformatf("v%0d rd strobes", i), n_rd - b_rd, vecs[i].exp_rd);
      if (vecs[i].nbytes > 1) chk($sformatf("v%0d addr", i), {24'd0, cap_addr}, {24'd0, vecs[i].addr});
      if (vecs[i].nbytes > 2) chk($sformatf("v%0d wdata", i), {24'd0, cap_wdata}, {24'd0, vecs[i].data});
      tick();
    end

    // Ack timeout: reply 'E' exactly AT+1 clocks after the strobe
    b_rd = n_rd;
    send_byte(8'h52); send_byte(8'h01);
    wait_tx("ack timeout wait");
    tick();
    chk("ack timeout byte", {24'd0, cap_tx}, 32'h45);
    chk("ack timeout latency", valid_cyc - strobe_cyc, AT + 1);
    chk("ack timeout rd strobe", n_rd - b_rd, 1);
    tick();

    // Frame timeout: abandoned frame is silent, next frame is normal
    b_wr = n_wr; b_rd = n_rd; b_tx = n_tx;
    send_byte(8'h57); send_byte(8'h10);
    repeat (FT + 5) tick();
    chk("frame timeout no strobe", n_wr + n_rd - b_wr - b_rd, 0);
    chk("frame timeout no tx", n_tx - b_tx, 0);
    send_byte(8'h52); send_byte(8'h05);
    do_ack(0, 8'h99);
    wait_tx("post timeout wait");
    tick();
    chk("post timeout tx", {24'd0, cap_tx}, 32'h99);
    chk("post timeout rd addr", {24'd0, cap_addr}, 32'h05);
    chk("post timeout rd count", n_rd - b_rd, 1);
    tick();

    // Gap just under the frame timeout is still accepted
    b_wr = n_wr;
    send_byte(8'h57); send_byte(8'h44);
    repeat (FT - 5) tick();
    send_byte(8'h11);
    do_ack(1, 8'h00);
    wait_tx("slow frame wait");
    tick();
    chk("slow frame tx", {24'd0, cap_tx}, 32'h4B);
    chk("slow frame wdata", {24'd0, cap_wdata}, 32'h11);
    chk("slow frame wr count", n_wr - b_wr, 1);
    tick();

    // Overrun in BUS_WAIT and in SEND under backpressure
    b_ovr = n_ovr; b_tx = n_tx;
    tx_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h06);
    send_byte(8'hEE);
    do_ack(1, 8'h77);
    wait_tx("backpressure wait");
    send_byte(8'h52);
    repeat (4) tick();
    chk("overrun pulses", n_ovr - b_ovr, 2);
    chk("held tx byte", {24'd0, tx_byte}, 32'h77);
    chk("held tx valid", {31'd0, tx_valid}, 1);
    chk("no transfer while not ready", n_tx - b_tx, 0);
    tx_ready = 1'b1;
    tick();
    chk("backpressure tx byte", {24'd0, cap_tx}, 32'h77);
    chk("backpressure tx count", n_tx - b_tx, 1);
    tick();
    // The dropped 'R' must not have started a frame: 00 is a bad command
    send_byte(8'h00);
    wait_tx("dropped byte wait");
    tick();
    chk("dropped byte ignored", {24'd0, cap_tx}, 32'h3F);
    tick();

    // Reset mid-frame aborts the frame
    b_wr = n_wr;
    send_byte(8'h57); send_byte(8'h10);
    rst = 1'b1; tick(); rst = 1'b0;
    send_byte(8'h00);
    wait_tx("mid-frame reset wait");
    tick();
    chk("mid-frame reset reply", {24'd0, cap_tx}, 32'h3F);
    chk("mid-frame reset no wr", n_wr - b_wr, 0);
    tick();

    // Reset mid-SEND drops the reply
    b_tx = n_tx;
    tx_ready = 1'b0;
    send_byte(8'h01);
    wait_tx("mid-send wait");
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid-send reset valid", {31'd0, tx_valid}, 0);
    chk("mid-send reset byte", {24'd0, tx_byte}, 0);
    tx_ready = 1'b1;
    repeat (3) tick();
    chk("mid-send reset no tx", n_tx - b_tx, 0);

    chk("wr and rd never together", n_both, 0);
    chk("tx byte stable while held", n_unstable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
